// File: rtl/scene_cmd_parser_pkg.sv
// Shared types for the scene command parser: model instance layout, scene metadata,
// opcode defaults and the parser state encoding.
package scene_cmd_parser_pkg;

    localparam int DATA_W = 8;

    typedef struct packed {
        logic        [7:0]  model_id;
        logic signed [11:0] pos_x;
        logic signed [11:0] pos_y;
        logic        [5:0]  rot;
        logic        [4:0]  scale;
    } modelinstance_t;

    typedef struct packed {
        logic       last;
        logic [3:0] layer;
    } modelinstance_meta_t;

    localparam int MODELINSTANCE_W     = $bits(modelinstance_t);
    localparam int MODELINSTANCE_BYTES = (MODELINSTANCE_W + DATA_W - 1) / DATA_W;

    localparam logic [DATA_W-1:0] OP_ADD_DEFAULT      = 8'h01;
    localparam logic [DATA_W-1:0] OP_ADD_LAST_DEFAULT = 8'h02;
    localparam int                TIMEOUT_CYCLES_DEFAULT = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        EMIT    = 2'd2
    } scene_cmd_state_t;

endpackage

// File: rtl/scene_cmd_parser.sv
// Decodes MCU command packets into model instances for the scene buffer write port.
// Define SCENE_CMD_PARSER_TIMEOUT_EN to abort payloads that stall for TIMEOUT_CYCLES.
module scene_cmd_parser
    import scene_cmd_parser_pkg::*;
#(
    parameter logic [DATA_W-1:0] OP_ADD         = OP_ADD_DEFAULT,
    parameter logic [DATA_W-1:0] OP_ADD_LAST    = OP_ADD_LAST_DEFAULT,
    parameter int                TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output modelinstance_t      out_data,
    output modelinstance_meta_t out_metadata,
    output logic                err_opcode,
    output logic                err_timeout
);

    localparam int PB    = MODELINSTANCE_BYTES;
    localparam int CNT_W = $clog2(PB + 1);

    scene_cmd_state_t            state_q, state_d;
    logic [CNT_W-1:0]            cnt_q;
    logic                        last_q;
    logic [MODELINSTANCE_W-1:0]  asm_q;
    logic                        run_q;
    logic                        err_opcode_q;
    logic                        byte_fire;
    logic                        op_known;
    logic                        final_byte;
    logic                        timeout_hit;

    assign byte_fire  = in_valid && in_ready;
    assign op_known   = (in_data == OP_ADD) || (in_data == OP_ADD_LAST);
    assign final_byte = (cnt_q == CNT_W'(PB - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (byte_fire && op_known) state_d = PAYLOAD;
            PAYLOAD: begin
                if (byte_fire && final_byte) state_d = EMIT;
                else if (timeout_hit)        state_d = IDLE;
            end
            EMIT:    if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready is held low for the first cycle after reset release via run_q
    always_comb begin
        in_ready            = run_q && (state_q != EMIT);
        out_valid           = (state_q == EMIT);
        out_metadata        = '0;
        out_metadata.last   = (state_q == EMIT) && last_q;
    end

    assign out_data   = asm_q;
    assign err_opcode = err_opcode_q;

    // Bytes enter MSB first; the shift drops pad bits of the leading byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q        <= 1'b0;
            err_opcode_q <= 1'b0;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            asm_q        <= '0;
        end else begin
            run_q        <= 1'b1;
            err_opcode_q <= (state_q == IDLE) && byte_fire && !op_known;
            if ((state_q == IDLE) && byte_fire && op_known) begin
                last_q <= (in_data == OP_ADD_LAST);
                cnt_q  <= '0;
            end
            if ((state_q == PAYLOAD) && byte_fire) begin
                asm_q <= MODELINSTANCE_W'({asm_q, in_data});
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef SCENE_CMD_PARSER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] tcnt_q;
    logic            err_timeout_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive byte-less cycle in PAYLOAD
    assign timeout_hit = (state_q == PAYLOAD) && !byte_fire &&
                         (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q        <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            err_timeout_q <= timeout_hit;
            if ((state_q != PAYLOAD) || byte_fire) tcnt_q <= '0;
            else                                   tcnt_q <= tcnt_q + 1'b1;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule
